// File: rtl/hist_addr_distributer.sv
`default_nettype none
// ============================================================================
//  Module      : hist_addr_distributer
//  Description : Classifies coincidence events (start channel, end channel,
//                coarse interval) into a histogram bin around CENTER, buffers
//                the bin addresses in a show-ahead FIFO and hands them to the
//                histogram incrementer over a valid/ready handshake. Events
//                that cannot be binned are counted in drop_cnt.
//  Config      : define HIST_DROP_CNT_EN to build the saturating drop counter;
//                when undefined, drop_cnt is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module hist_addr_distributer #(
   parameter int CH_W       = 2,
   parameter int INT_W      = 7,
   parameter int ADDR_W     = 8,
   parameter int CENTER     = 128,
   parameter int CH_A       = 1,
   parameter int CH_B       = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH_W-1:0]   START,
   input  logic [CH_W-1:0]   END,
   input  logic [INT_W-1:0]  INTERVAL,
   input  logic              data_arrived,
   output logic [ADDR_W-1:0] inc_addr,
   output logic              inc_valid,
   input  logic              inc_ready,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              fifo_full
);

   // Two guard bits above the address: one absorbs CENTER+INTERVAL carry,
   // the top one acts as sign, so out-of-range results are never wrapped.
   localparam int SW    = ADDR_W + 2;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CH_W-1:0]  c_CH_A   = CH_W'(CH_A);
   localparam logic [CH_W-1:0]  c_CH_B   = CH_W'(CH_B);
   localparam logic [SW-1:0]    c_CENTER = SW'(CENTER);
   localparam logic [PTR_W:0]   c_DEPTH  = (PTR_W+1)'(FIFO_DEPTH);

   // ---------------------------------------------------------------- capture
   logic              r_meta;
   logic              r_sync;
   logic              r_sync_d;
   logic              w_rise;
   logic              r_evt;
   logic [CH_W-1:0]   r_start;
   logic [CH_W-1:0]   r_end;
   logic [INT_W-1:0]  r_interval;

   assign w_rise = r_sync & ~r_sync_d;

   // Synchronise the strobe, detect its rising edge and latch the event fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta     <= 1'b0;
         r_sync     <= 1'b0;
         r_sync_d   <= 1'b0;
         r_evt      <= 1'b0;
         r_start    <= '0;
         r_end      <= '0;
         r_interval <= '0;
      end else begin
         r_meta   <= data_arrived;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_evt    <= w_rise;
         if (w_rise) begin
            r_start    <= START;
            r_end      <= END;
            r_interval <= INTERVAL;
         end
      end
   end

   // --------------------------------------------------------------- classify
   logic [SW-1:0]     w_ival;
   logic [SW-1:0]     w_sum;
   logic              w_cls_ok;
   logic              r_cls_v;
   logic              r_cls_ok;
   logic [ADDR_W-1:0] r_cls_addr;

   assign w_ival = SW'(r_interval);

   // Map the latched codes to a bin; anything unrecognised or out of range fails
   always_comb begin
      w_sum    = c_CENTER;
      w_cls_ok = 1'b0;
      if (r_start == '0 && r_end == '1 && r_interval == '0) begin
         w_sum    = c_CENTER;
         w_cls_ok = 1'b1;
      end else if (r_start == c_CH_A && r_end == c_CH_B) begin
         w_sum    = c_CENTER + w_ival;
         w_cls_ok = (w_sum[SW-1:ADDR_W] == '0);
      end else if (r_start == c_CH_B && r_end == c_CH_A) begin
         w_sum    = c_CENTER - w_ival;
         w_cls_ok = (w_sum[SW-1:ADDR_W] == '0);
      end
   end

   // Register the classification result one cycle after capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cls_v    <= 1'b0;
         r_cls_ok   <= 1'b0;
         r_cls_addr <= '0;
      end else begin
         r_cls_v    <= r_evt;
         r_cls_ok   <= w_cls_ok;
         r_cls_addr <= w_sum[ADDR_W-1:0];
      end
   end

   // ------------------------------------------------------------------- FIFO
   logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              w_wr;
   logic              w_rd;

   // Fullness is judged before any same-cycle read, so a write into a full
   // FIFO is always rejected even when the head is leaving.
   assign fifo_full = (r_count == c_DEPTH);
   assign inc_valid = (r_count != '0);
   assign inc_addr  = inc_valid ? r_mem[r_rd_ptr] : '0;
   assign w_rd      = inc_valid & inc_ready;
   assign w_wr      = r_cls_v & r_cls_ok & ~fifo_full;

   // Storage array; contents are only observable through a valid head entry
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= r_cls_addr;
      end
   end

   // Pointer and occupancy bookkeeping; reset flushes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ----------------------------------------------------------- drop counter
`ifdef HIST_DROP_CNT_EN
   logic             w_drop;
   logic [CNT_W-1:0] r_drop_cnt;

   // Events reach this point at most one per clock, so a single increment suffices
   assign w_drop   = r_cls_v & (~r_cls_ok | fifo_full);
   assign drop_cnt = r_drop_cnt;

   // Saturating count of discarded events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_drop && r_drop_cnt != '1) begin
         r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end
`else
   assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hist_addr_distributer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hist_addr_distributer
//  Description : Scoreboard bench for hist_addr_distributer. Stimulus pushes
//                expected bin addresses; a negedge monitor pops and compares
//                on every valid/ready transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_addr_distributer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  start_ch;
   logic [1:0]  end_ch;
   logic [6:0]  interval;
   logic        data_arrived;
   logic [7:0]  inc_addr;
   logic        inc_valid;
   logic        inc_ready;
   logic [15:0] drop_cnt;
   logic        fifo_full;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_xfer = 0;
   int          exp_drop = 0;
   int          rise_cyc = -1;
   logic        prev_valid = 1'b0;
   logic [7:0]  exp_q [$];

   hist_addr_distributer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .START        (start_ch),
      .END          (end_ch),
      .INTERVAL     (interval),
      .data_arrived (data_arrived),
      .inc_addr     (inc_addr),
      .inc_valid    (inc_valid),
      .inc_ready    (inc_ready),
      .drop_cnt     (drop_cnt),
      .fifo_full    (fifo_full)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int exp_dc();
`ifdef HIST_DROP_CNT_EN
      return exp_drop;
`else
      return 0;
`endif
   endfunction

   // Monitor: compare every handshake transfer against the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (inc_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = inc_valid;
         if (inc_valid && inc_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check("unexpected_addr", int'(inc_addr), -1);
            else check("addr", int'(inc_addr), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One strobe pulse; fields stay put until after the capture edge
   task automatic send(input int s, input int e, input int i);
      start_ch     = 2'(s);
      end_ch       = 2'(e);
      interval     = 7'(i);
      data_arrived = 1'b1;
      tick();
      data_arrived = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic ev_ok(input int s, input int e, input int i, input int addr);
      exp_q.push_back(8'(addr));
      send(s, e, i);
   endtask

   task automatic ev_drop(input int s, input int e, input int i);
      exp_drop++;
      send(s, e, i);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 60 && (exp_q.size() != 0 || inc_valid); k++) tick();
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int c0;
      int x0;
      rst_n        = 1'b0;
      start_ch     = '0;
      end_ch       = '0;
      interval     = '0;
      data_arrived = 1'b0;
      inc_ready    = 1'b1;
      tick(); tick(); tick();
      check("rst_inc_valid", int'(inc_valid), 0);
      check("rst_inc_addr",  int'(inc_addr),  0);
      check("rst_drop_cnt",  int'(drop_cnt),  0);
      check("rst_fifo_full", int'(fifo_full), 0);
      rst_n = 1'b1;
      tick(); tick();

      // zero-delay code, latency from first synchroniser sample
      n_xfer = 0;
      c0 = cyc + 1;
      ev_ok(0, 3, 0, 128);
      wait_drain();
      check("latency_e0_to_valid", rise_cyc - c0, 4);
      check("single_transfer", n_xfer, 1);

      // signed offsets, including both edges of the address range
      ev_ok(1, 2, 5, 133);
      ev_ok(2, 1, 5, 123);
      ev_ok(2, 1, 127, 1);
      ev_ok(1, 2, 127, 255);
      wait_drain();
      check("xfer_after_offsets", n_xfer, 5);

      // unclassifiable codes
      ev_drop(1, 1, 9);
      tick(); tick(); tick(); tick();
      check("drop_same_channel", int'(drop_cnt), exp_dc());
      ev_drop(0, 3, 4);
      tick(); tick(); tick(); tick();
      check("drop_bad_zero_code", int'(drop_cnt), exp_dc());
      check("no_xfer_on_drop", n_xfer, 5);

      // fill FIFO with sink stalled, two overflow drops
      inc_ready = 1'b0;
      ev_ok(1, 2, 2, 130);
      ev_ok(1, 2, 3, 131);
      ev_ok(1, 2, 4, 132);
      ev_ok(1, 2, 5, 133);
      ev_drop(1, 2, 6);
      ev_drop(1, 2, 7);
      tick(); tick(); tick(); tick();
      check("full_flag", int'(fifo_full), 1);
      check("full_drop_cnt", int'(drop_cnt), exp_dc());
      check("stalled_valid", int'(inc_valid), 1);
      check("stalled_head", int'(inc_addr), 130);
      inc_ready = 1'b1;
      wait_drain();
      check("full_cleared", int'(fifo_full), 0);
      check("xfer_after_full", n_xfer, 9);

      // reset while three entries are pending
      inc_ready = 1'b0;
      send(1, 2, 10);
      send(2, 1, 10);
      send(0, 3, 0);
      tick(); tick(); tick(); tick();
      check("pre_reset_valid", int'(inc_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_inc_valid", int'(inc_valid), 0);
      check("midrst_drop_cnt",  int'(drop_cnt),  0);
      check("midrst_fifo_full", int'(fifo_full), 0);
      exp_drop = 0;
      exp_q.delete();
      tick(); tick();
      rst_n     = 1'b1;
      inc_ready = 1'b1;
      x0 = n_xfer;
      repeat (10) tick();
      check("no_stale_xfer", n_xfer, x0);
      check("no_stale_valid", int'(inc_valid), 0);
      ev_ok(1, 2, 1, 129);
      wait_drain();
      check("post_reset_xfer", n_xfer, x0 + 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
